circuito_jogo_param: RTL and testbench
======================================

// Module: circuito_jogo_param
// PURPOSE
//  Parametrised successor of the experiment-4 play-checker: runs a full round of up to N_JOGADAS plays.
//  Each play (rising edge of any switch) is registered and compared with a programmable sequence memory.
//  Ends in win, error or per-play timeout. Raw debug nibbles feed external hexa7seg displays at top level.
// PARAMETERS
//  WIDTH      4     width of chaves, sequence words and leds
//  N_JOGADAS  16    sequence memory depth (power of 2, >=2); ADDR_W = $clog2(N_JOGADAS)
//  TIMEOUT    5000  clock cycles allowed in ESPERA per play (>=2); TW = $clog2(TIMEOUT+1)
// PORTS
//  clock          in   1       system clock, all state on rising edge
//  reset          in   1       asynchronous, active-low; 0 forces reset state immediately
//  iniciar        in   1       level; sampled in INICIAL and FIM_* states
//  chaves         in   WIDTH   player switches
//  limite         in   ADDR_W  index of last play; round length = limite+1; sampled in PREPARA
//  prog_we        in   1       sequence write enable
//  prog_addr      in   ADDR_W  sequence write address
//  prog_data      in   WIDTH   sequence write data
//  acertou        out  1       1 in FIM_ACERTO
//  errou          out  1       1 in FIM_ERRO
//  timeout        out  1       1 in FIM_TIMEOUT
//  pronto         out  1       1 in any FIM_* state
//  leds           out  WIDTH   mem[contagem] (expected play)
//  db_tem_jogada  out  1       |chaves (combinational)
//  db_igual       out  1       jogada register == mem[contagem] (combinational)
//  db_estado      out  4       state code (below)
//  db_contagem    out  ADDR_W  play counter
//  db_jogada      out  WIDTH   jogada register
// BEHAVIOUR
//  Reset (reset=0): state=INICIAL, contagem=0, jogada reg=0, timer=0, limite reg=0, edge reg=0;
//   all status outputs 0. Memory is NOT cleared (power-up contents undefined).
//  Play detect: tem_r <= |chaves each cycle; jogada pulse = (|chaves) & ~tem_r.
//   One pulse per 0->nonzero transition; holding switches gives no further pulses.
//  Memory: N_JOGADAS x WIDTH regs, async read at contagem. Write at clock edge when prog_we=1
//   and state is INICIAL or FIM_*; prog_we ignored in all other states.
//  Moore FSM (code: name -> transitions):
//   0 INICIAL     : iniciar -> PREPARA
//   1 PREPARA     : contagem=0, jogada reg=0, timer=0, latch limite -> ESPERA
//   2 ESPERA      : timer++; jogada pulse -> REGISTRA (pulse wins over simultaneous expiry);
//                   else timer==TIMEOUT-1 -> FIM_TIMEOUT
//   4 REGISTRA    : jogada reg <= chaves -> COMPARA
//   5 COMPARA     : !igual -> FIM_ERRO; igual & contagem==limite reg -> FIM_ACERTO; igual -> PROXIMO
//   6 PROXIMO     : contagem++, timer=0 -> ESPERA
//   A FIM_ACERTO, E FIM_ERRO, D FIM_TIMEOUT : hold outputs; iniciar -> PREPARA
//   Unused codes -> INICIAL.
//  Latency: iniciar seen in INICIAL -> PREPARA next cycle -> ESPERA after that.
//   Pulse in ESPERA -> REGISTRA(+1) -> COMPARA(+2) -> PROXIMO/FIM(+3).
//  Counter never wraps: the round ends at contagem==limite before overflow; limite=N_JOGADAS-1 is legal.
//  Switches held through REGISTRA/COMPARA produce no extra play; the next play needs a return to 0.
//  Timeout: exactly TIMEOUT cycles in ESPERA without a pulse; the timer restarts on every PROXIMO.
//  Timeout is the only modo added over exp4; the switch-value encoding (any nonzero) is unchanged.
// TESTING (WIDTH=4, N_JOGADAS=4, TIMEOUT=8)
//  1 prog mem={1,2,4,8}, limite=3, iniciar, plays 1,2,4,8 (0 between)
//    -> acertou=1, pronto=1, db_estado=A, db_contagem=3
//  2 same mem, plays 1,2,2 -> errou=1, pronto=1, db_estado=E, db_contagem=2, db_jogada=2
//  3 limite=1, plays 1,2 -> acertou=1 after 2nd play, db_contagem=1; iniciar -> new round, contagem=0
//  4 iniciar, no play -> 8 cycles in ESPERA then timeout=1, db_estado=D, db_contagem=0;
//    pulse on the 8th cycle -> REGISTRA instead
//  5 reset=0 mid-round (contagem=2) -> async: db_estado=0, all status 0;
//    release, replay 1,2,4,8 -> acertou (memory retained)
//  6 chaves=1 held 5 cycles -> one play only; prog_we in ESPERA (addr 0, data F) -> mem[0] still 1

Source files
------------

// File: rtl/circuito_jogo_param_if.sv
// circuito_jogo_param_if: player, programming and debug signals of the parametrised play-checker
interface circuito_jogo_param_if #(
  parameter int WIDTH  = 4,
  parameter int ADDR_W = 4
);
  logic              iniciar;
  logic [WIDTH-1:0]  chaves;
  logic [ADDR_W-1:0] limite;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [WIDTH-1:0]  prog_data;
  logic              acertou;
  logic              errou;
  logic              timeout;
  logic              pronto;
  logic [WIDTH-1:0]  leds;
  logic              db_tem_jogada;
  logic              db_igual;
  logic [3:0]        db_estado;
  logic [ADDR_W-1:0] db_contagem;
  logic [WIDTH-1:0]  db_jogada;
  modport master (
    output iniciar, chaves, limite, prog_we, prog_addr, prog_data,
    input  acertou, errou, timeout, pronto, leds, db_tem_jogada, db_igual, db_estado, db_contagem, db_jogada
  );
  modport slave (
    input  iniciar, chaves, limite, prog_we, prog_addr, prog_data,
    output acertou, errou, timeout, pronto, leds, db_tem_jogada, db_igual, db_estado, db_contagem, db_jogada
  );
endinterface

// File: rtl/circuito_jogo_param.sv
// circuito_jogo_param: round of up to N_JOGADAS plays checked against a programmable sequence, with per-play timeout
module circuito_jogo_param #(
  parameter int WIDTH     = 4,
  parameter int N_JOGADAS = 16,
  parameter int TIMEOUT   = 5000
) (
  input logic clock,
  input logic reset,
  circuito_jogo_param_if.slave bus
);
  localparam int ADDR_W = $clog2(N_JOGADAS);
  localparam int TW     = $clog2(TIMEOUT + 1);
  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARA     = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h4,
    COMPARA     = 4'h5,
    PROXIMO     = 4'h6,
    FIM_ACERTO  = 4'hA,
    FIM_TIMEOUT = 4'hD,
    FIM_ERRO    = 4'hE
  } estado_t;
  estado_t           state_q, state_d;
  logic [ADDR_W-1:0] cont_q, cont_d, lim_q, lim_d;
  logic [WIDTH-1:0]  jog_q, jog_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              tem_q, tem_d;
  logic [WIDTH-1:0]  mem_q [N_JOGADAS];
  logic [WIDTH-1:0]  esperado;
  logic              pulso, igual, fim, we_ok;
  assign esperado = mem_q[cont_q];
  assign tem_d    = |bus.chaves;
  assign pulso    = tem_d & ~tem_q;
  assign igual    = jog_q == esperado;
  assign fim      = state_q == FIM_ACERTO || state_q == FIM_ERRO || state_q == FIM_TIMEOUT;
  assign we_ok    = bus.prog_we & (fim | state_q == INICIAL);
  always_comb begin
    state_d = state_q;
    cont_d  = cont_q;
    lim_d   = lim_q;
    jog_d   = jog_q;
    timer_d = timer_q;
    case (state_q)
      INICIAL: state_d = bus.iniciar ? PREPARA : INICIAL;
      PREPARA: begin
        cont_d  = '0;
        jog_d   = '0;
        timer_d = '0;
        lim_d   = bus.limite;
        state_d = ESPERA;
      end
      ESPERA: begin
        timer_d = timer_q + 1'b1;
        state_d = pulso ? REGISTRA : (timer_q == TW'(TIMEOUT - 1)) ? FIM_TIMEOUT : ESPERA;
      end
      REGISTRA: begin
        jog_d   = bus.chaves;
        state_d = COMPARA;
      end
      COMPARA: state_d = !igual ? FIM_ERRO : (cont_q == lim_q) ? FIM_ACERTO : PROXIMO;
      PROXIMO: begin
        cont_d  = cont_q + 1'b1;
        timer_d = '0;
        state_d = ESPERA;
      end
      FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: state_d = bus.iniciar ? PREPARA : state_q;
      default: state_d = INICIAL;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= INICIAL;
      cont_q  <= '0;
      lim_q   <= '0;
      jog_q   <= '0;
      timer_q <= '0;
      tem_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cont_q  <= cont_d;
      lim_q   <= lim_d;
      jog_q   <= jog_d;
      timer_q <= timer_d;
      tem_q   <= tem_d;
    end
  end
  always_ff @(posedge clock) begin
    if (we_ok) mem_q[bus.prog_addr] <= bus.prog_data;
  end
  assign bus.acertou       = state_q == FIM_ACERTO;
  assign bus.errou         = state_q == FIM_ERRO;
  assign bus.timeout       = state_q == FIM_TIMEOUT;
  assign bus.pronto        = fim;
  assign bus.leds          = esperado;
  assign bus.db_tem_jogada = tem_d;
  assign bus.db_igual      = igual;
  assign bus.db_estado     = state_q;
  assign bus.db_contagem   = cont_q;
  assign bus.db_jogada     = jog_q;
endmodule

// File: tb/tb_circuito_jogo_param.sv
// tb_circuito_jogo_param: scoreboard bench; round outcomes predicted from a sequence model, checked when pronto rises
module tb_circuito_jogo_param;
  typedef struct {
    logic [3:0] est;
    logic [1:0] cnt;
    logic [3:0] jog;
  } exp_t;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   mem_m [4];
  exp_t sb [$];
  logic pronto_prev = 1'b0;
  int   pl [$];
  circuito_jogo_param_if #(.WIDTH(4), .ADDR_W(2)) bus ();
  circuito_jogo_param #(.WIDTH(4), .N_JOGADAS(4), .TIMEOUT(8)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask
  function automatic exp_t model(input int lim, input int plays [$]);
    exp_t e;
    e.est = 4'hD;
    e.jog = '0;
    e.cnt = 2'(plays.size());
    for (int i = 0; i < plays.size(); i++) begin
      e.jog = 4'(plays[i]);
      e.cnt = 2'(i);
      if (plays[i] != mem_m[i]) begin
        e.est = 4'hE;
        return e;
      end
      if (i == lim) begin
        e.est = 4'hA;
        return e;
      end
    end
    e.cnt = 2'(plays.size());
    return e;
  endfunction
  task automatic push(input int lim, input int plays [$]);
    sb.push_back(model(lim, plays));
  endtask
  task automatic prog(input int a, input int d);
    bus.prog_we   = 1'b1;
    bus.prog_addr = 2'(a);
    bus.prog_data = 4'(d);
    tick(1);
    bus.prog_we = 1'b0;
    mem_m[a] = d;
  endtask
  task automatic start(input int lim);
    bus.limite  = 2'(lim);
    bus.iniciar = 1'b1;
    tick(1);
    bus.iniciar = 1'b0;
    tick(1);
  endtask
  task automatic do_plays(input int plays [$]);
    foreach (plays[i]) begin
      bus.chaves = 4'(plays[i]);
      tick(3);
      bus.chaves = '0;
      tick(1);
    end
  endtask
  task automatic wait_done();
    int n = 0;
    while (!bus.pronto && n < 40) begin
      tick(1);
      n++;
    end
    chk("done_wait", 32'(bus.pronto), 1);
    tick(1);
  endtask
  always @(negedge clock) begin : mon
    exp_t e;
    logic [2:0] st;
    if (bus.pronto && !pronto_prev) begin
      if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
      else begin
        e  = sb.pop_front();
        st = (e.est == 4'hA) ? 3'b100 : (e.est == 4'hE) ? 3'b010 : 3'b001;
        chk("sb_estado", 32'(bus.db_estado), 32'(e.est));
        chk("sb_contagem", 32'(bus.db_contagem), 32'(e.cnt));
        chk("sb_jogada", 32'(bus.db_jogada), 32'(e.jog));
        chk("sb_status", 32'({bus.acertou, bus.errou, bus.timeout}), 32'(st));
      end
    end
    pronto_prev <= bus.pronto;
  end
  initial begin
    bus.iniciar   = 1'b0;
    bus.chaves    = '0;
    bus.limite    = '0;
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    #12;
    chk("rst_estado", 32'(bus.db_estado), 0);
    chk("rst_status", 32'({bus.acertou, bus.errou, bus.timeout, bus.pronto}), 0);
    chk("rst_contagem", 32'(bus.db_contagem), 0);
    chk("rst_jogada", 32'(bus.db_jogada), 0);
    @(negedge clock);
    reset = 1'b1;
    tick(1);
    prog(0, 1);
    prog(1, 2);
    prog(2, 4);
    prog(3, 8);
    chk("leds_mem0", 32'(bus.leds), 1);
    pl = '{1, 2, 4, 8};
    push(3, pl);
    start(3);
    do_plays(pl);
    wait_done();
    pl = '{1, 2, 2};
    push(3, pl);
    start(3);
    do_plays(pl);
    wait_done();
    pl = '{1, 2};
    push(1, pl);
    start(1);
    do_plays(pl);
    wait_done();
    pl = '{};
    push(3, pl);
    start(3);
    chk("new_round_cnt", 32'(bus.db_contagem), 0);
    chk("new_round_est", 32'(bus.db_estado), 2);
    tick(7);
    chk("esp_8th_cycle", 32'(bus.db_estado), 2);
    tick(1);
    chk("tmo_estado", 32'(bus.db_estado), 32'hD);
    wait_done();
    pl = '{1, 2, 4, 8};
    push(3, pl);
    start(3);
    tick(7);
    bus.chaves = 4'h1;
    tick(1);
    chk("pulse_8th_cycle", 32'(bus.db_estado), 4);
    tick(2);
    bus.chaves = '0;
    tick(1);
    pl = '{2, 4, 8};
    do_plays(pl);
    wait_done();
    start(3);
    pl = '{1, 2};
    do_plays(pl);
    chk("mid_contagem", 32'(bus.db_contagem), 2);
    #2 reset = 1'b0;
    #1;
    chk("async_estado", 32'(bus.db_estado), 0);
    chk("async_status", 32'({bus.acertou, bus.errou, bus.timeout, bus.pronto}), 0);
    chk("async_contagem", 32'(bus.db_contagem), 0);
    @(negedge clock);
    reset = 1'b1;
    tick(1);
    pl = '{1, 2, 4, 8};
    push(3, pl);
    start(3);
    do_plays(pl);
    wait_done();
    push(3, pl);
    start(3);
    bus.chaves = 4'h1;
    tick(5);
    chk("hold_contagem", 32'(bus.db_contagem), 1);
    chk("hold_estado", 32'(bus.db_estado), 2);
    bus.chaves = '0;
    tick(1);
    bus.prog_we   = 1'b1;
    bus.prog_addr = 2'd0;
    bus.prog_data = 4'hF;
    tick(1);
    bus.prog_we = 1'b0;
    pl = '{2, 4, 8};
    do_plays(pl);
    wait_done();
    pl = '{1, 2, 4, 8};
    push(3, pl);
    start(3);
    chk("mem0_kept", 32'(bus.leds), 1);
    do_plays(pl);
    wait_done();
    chk("sb_left", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
